// File: rtl/alu_skid_reg.sv
// Two-entry skid register between the ALU and the writeback/memory-address stage.
// Registered in_ready/out_valid/out_data, synchronous flush and a saturating stall counter.
module alu_skid_reg #(
  parameter int                 WIDTH       = 32,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter int                 CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, out_valid_q;
  logic [WIDTH-1:0]   main_q, skid_q;
  logic [CNT_W-1:0]   stall_q;

  logic push, pop;
  logic load_main, main_from_skid, load_skid;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // NOTE: every signal written in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            load_main = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          unique case ({push, pop})
            2'b11: load_main = 1'b1;
            2'b10: begin
              load_skid = 1'b1;
              state_d   = FULL;
            end
            2'b01:   state_d = EMPTY;
            default: state_d = ONE;
          endcase
        end
        FULL: begin
          if (pop) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake flags are registered from the next state so neither output
  // has a combinational path from out_ready or the in_* inputs.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  // NOTE: the data registers are reset on purpose so out_data shows a known
  // value straight after reset; they are two words, not a RAM array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

  // Saturating count of cycles where a held result was refused downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (flush) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

endmodule

// File: doc/alu_skid_reg.md
# alu_skid_reg

- Parametrised two-entry pipeline register with a valid/ready handshake, synchronous flush and a stall counter.
- Sits between the ALU and the writeback/memory-address stage of the multicycle core, replacing the single-cycle result latch.
- Lets the downstream stage stall without losing an ALU result and without a combinational path from `out_ready` back to `in_ready`.

## Interface

Parameters:
- `WIDTH`, 32: payload width in bits.
- `RESET_VALUE`, 0: value loaded into both data registers on reset; `WIDTH` bits.
- `CNT_W`, 8: stall-counter width.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: producer offers `in_data`.
- `in_data`, input, `WIDTH`: ALU result.
- `in_ready`, output, 1: block can accept this cycle; driven from a register.
- `out_valid`, output, 1: `out_data` holds a valid result.
- `out_data`, output, `WIDTH`: oldest held result; driven from a register.
- `out_ready`, input, 1: consumer takes `out_data` this cycle.
- `flush`, input, 1: synchronous discard of all held entries.
- `occupancy`, output, 2: number of held entries, 0 to 2.
- `stall_cnt`, output, `CNT_W`: saturating count of stalled cycles.

## Operation

Storage:
- `main_q` drives `out_data`.
- `skid_q` is the second entry.
- State is EMPTY, ONE or FULL.

Derived signals:
- `push = in_valid & in_ready`
- `pop = out_valid & out_ready`

Output decoding:
- `out_valid` = 1 in ONE and FULL.
- `in_ready` = 1 in EMPTY and ONE.
- `occupancy` = 0 in EMPTY, 1 in ONE, 2 in FULL.

Transitions (`flush` = 0):
- EMPTY, push: `main_q` <= `in_data`; go to ONE. No push: stay EMPTY.
- ONE, push and pop: `main_q` <= `in_data`; stay ONE.
- ONE, push only: `skid_q` <= `in_data`; go to FULL.
- ONE, pop only: go to EMPTY.
- ONE, neither: hold.
- FULL, pop: `main_q` <= `skid_q`; go to ONE. No pop: hold. A push is impossible here because `in_ready` = 0.

Flush:
- `flush` = 1 has priority over everything: next state is EMPTY and `stall_cnt` clears to 0.
- A push in the same cycle is accepted by the handshake and then dropped.
- A pop in the same cycle completes normally; the consumer does take `out_data`.
- Data registers keep their contents on flush; only `out_valid` is dropped.

Ordering:
- Results leave in acceptance order.
- No duplicates and no loss, except entries discarded by flush.

Stall counter:
- Increments by 1 in each cycle with `out_valid` = 1 and `out_ready` = 0.
- Saturates at 2^`CNT_W` − 1 and never wraps.
- Cleared only by `reset` or `flush`.

Reset (asynchronous assert):
- State EMPTY.
- `main_q` = `skid_q` = `RESET_VALUE`.
- Outputs: `out_valid` = 0, `in_ready` = 1, `occupancy` = 0, `stall_cnt` = 0, `out_data` = `RESET_VALUE`.
- Reset asserted mid-transfer discards all held data immediately, without waiting for a clock edge.

## Timing

- Latency: a result accepted at edge N is on `out_data` with `out_valid` = 1 after edge N.
- Throughput: one transfer per cycle, sustained indefinitely, while `out_ready` = 1.
- `in_ready` depends only on registered state, with no combinational path from `out_ready`.
- `out_data` and `out_valid` come directly from flops, with no combinational path from the `in_*` signals.
- Recovery from a full stall:
  - `in_ready` rises in the cycle after the first pop from FULL.
  - Re-fill resumes one cycle later.
- Reset release: the block accepts on the first rising edge after `reset` deasserts. `reset` deassertion is synchronised outside this block.

## Test plan

- **Reset values:** with `WIDTH`=32 and `RESET_VALUE`=0xDEADBEEF, assert `reset` between edges.
  - Outputs change immediately: `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=0xDEADBEEF.
- **Streaming:** push 0x1, 0x2, 0x3 on consecutive cycles with `out_ready`=1.
  - Outputs appear one cycle later in order, `occupancy` stays 1, `in_ready` never drops.
- **Stall and skid:** with `out_ready`=0, push 0xA then 0xB.
  - `occupancy`=2 and `in_ready`=0; a third offer 0xC is not accepted.
  - `stall_cnt` increments every stalled cycle.
  - Raise `out_ready`: outputs are 0xA then 0xB, and 0xC is accepted only after `in_ready` returns.
- **Flush:** in FULL, assert `flush` together with `in_valid`=0.
  - Next cycle: `out_valid`=0, `occupancy`=0, `stall_cnt`=0.
  - A push with `flush` in state ONE leaves the block EMPTY.
- **Saturation:** with `CNT_W`=4, hold a valid output with `out_ready`=0 for 20 cycles.
  - `stall_cnt` reads 15 and holds there.
- **Mid-operation reset:** assert `reset` asynchronously while in FULL.
  - `out_valid`=0 immediately; after release, 0x55 pushed alone emerges as the only output.
